// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit producing HI/LO register writes
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        write_en,
  output logic [31:0] hi_write_data,
  output logic [31:0] lo_write_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        last;
  logic        is_div;
  logic        div_zero;
  logic        neg_res;
  logic        neg_rem;
  logic [31:0] a_raw;
  logic [31:0] addend;
  logic [63:0] acc;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] sum, rem_shift, diff;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem;

  assign busy     = (state != IDLE);
  assign write_en = (state == DONE);

  // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & src_a[31];
    b_neg     = signed_op & src_b[31];
    a_abs     = a_neg ? (~src_a + 32'd1) : src_a;
    b_abs     = b_neg ? (~src_b + 32'd1) : src_b;
    sum       = {1'b0, acc[63:32]} + {1'b0, addend};
    rem_shift = {acc[63:32], acc[31]};
    diff      = rem_shift - {1'b0, addend};
    mul_next  = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    div_next  = diff[32] ? {rem_shift[31:0], acc[30:0], 1'b0}
                         : {diff[31:0], acc[30:0], 1'b1};
    prod      = neg_res ? (~acc + 64'd1) : acc;
    quo       = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem       = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= 5'd0;
      last          <= 1'b0;
      is_div        <= 1'b0;
      div_zero      <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      a_raw         <= 32'd0;
      addend        <= 32'd0;
      acc           <= 64'd0;
      hi_write_data <= 32'd0;
      lo_write_data <= 32'd0;
    end else if (cancel) begin
      state <= IDLE;
      count <= 5'd0;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            count    <= 5'd0;
            last     <= 1'b0;
            is_div   <= op[1];
            div_zero <= (src_b == 32'd0);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            a_raw    <= src_a;
            addend   <= op[1] ? b_abs : a_abs;
            acc      <= op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
          end
        end
        CALC: begin
          if (!last) begin
            acc   <= is_div ? div_next : mul_next;
            count <= count + 5'd1;
            if (count == 5'd31) last <= 1'b1;
          end else begin
            // extra cycle after the 32nd iteration applies sign/zero fix-ups
            state <= DONE;
            last  <= 1'b0;
            if (!is_div) begin
              hi_write_data <= prod[63:32];
              lo_write_data <= prod[31:0];
            end else if (div_zero) begin
              hi_write_data <= a_raw;
              lo_write_data <= 32'hFFFF_FFFF;
            end else begin
              hi_write_data <= rem;
              lo_write_data <= quo;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, write_en;
  logic [31:0] hi_write_data, lo_write_data;

  int tests = 0;
  int fails = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .write_en(write_en),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    longint sp;
    longint unsigned up;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin sp = longint'(sa) * longint'(sb); return sp; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(input int so_far, input string name, input logic [63:0] exp);
    int n;
    n = so_far;
    while (!write_en && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, 33);
    check({name, " result"}, {hi_write_data, lo_write_data}, exp);
    @(posedge clk); #1;
    check({name, " pulse/hold"}, {write_en, busy, hi_write_data, lo_write_data}, {2'b00, exp});
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = 1'b1;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [63:0] exp);
    launch(o, a, b);
    wait_done(0, name, exp);
  endtask

  initial begin
    logic [63:0] prev;
    logic        saw_we;
    int          n;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
    vecs[4] = '{2'd3, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[7] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[8] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
    vecs[9] = '{2'd1, 32'h0000_0000, 32'h0001_2345, 64'h0000_0000_0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset state", {busy, write_en, hi_write_data, lo_write_data}, 66'd0);

    // first launch releases reset on the same negedge, so start meets the first edge with rst=1
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 8 == 0) ? 32'd0 : ((i % 5 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      run_op(o, a, b, $sformatf("rand%0d", i), ref_model(o, a, b));
    end

    // start during CALC is ignored and not queued
    launch(2'd1, 32'd5, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd0; src_a = 32'd100; src_b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, "start ignored", 64'd35);
    @(posedge clk); #1;
    check("start not queued", busy, 1'b0);

    // cancel mid-CALC aborts with no write and data held
    prev = {hi_write_data, lo_write_data};
    launch(2'd3, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel to idle", busy, 1'b0);
    saw_we = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      saw_we |= write_en;
    end
    check("cancel no write_en", saw_we, 1'b0);
    check("cancel data held", {hi_write_data, lo_write_data}, prev);
    run_op(2'd3, 32'd1000, 32'd3, "after cancel", {32'd1, 32'd333});

    // start and cancel on the same idle edge: cancel wins
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start+cancel idle", busy, 1'b0);

    // cancel during DONE keeps that cycle's write pulse
    launch(2'd1, 32'd7, 32'd9);
    n = 0;
    while (!write_en && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    cancel = 1'b1;
    #1;
    check("cancel in done pulse", {write_en, 6'(n)}, {1'b1, 6'd33});
    check("cancel in done data", {hi_write_data, lo_write_data}, 64'd63);
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel in done idle", {busy, write_en}, 2'b00);

    // asynchronous reset mid-CALC clears everything at once
    launch(2'd0, 32'hFFFF_FFF0, 32'd3);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async reset", {busy, write_en, hi_write_data, lo_write_data}, 66'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_we = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_we |= write_en | busy;
    end
    check("no write after reset", saw_we, 1'b0);
    run_op(2'd0, 32'hFFFF_FFF0, 32'd3, "after reset", 64'hFFFF_FFFF_FFFF_FFD0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
